// File: rtl/memory.sv
// Single-port register-file memory with registered read data, write-first
// same-cycle behaviour and a synchronous clear of every word on reset.
module memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  in_range_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    // Decode whether the address maps onto an implemented word
    always_comb begin
        in_range_s = 1'b0;
        if ({1'b0, address} < DEPTH_W) begin
            in_range_s = 1'b1;
        end else begin
            in_range_s = 1'b0;
        end
    end

    // Read data selection: unmapped reads give zero, a concurrent write wins
    always_comb begin
        rd_data_s = '0;
        if (!in_range_s) begin
            rd_data_s = '0;
        end else if (write_enable) begin
            rd_data_s = data_in;
        end else begin
            rd_data_s = mem_r[address];
        end
    end

    // Storage and read register; reset clears everything and discards any access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            data_out_r <= '0;
        end else begin
            if (write_enable && in_range_s) begin
                mem_r[address] <= data_in;
            end
            if (read_enable) begin
                data_out_r <= rd_data_s;
            end
        end
    end

    assign data_out = data_out_r;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  address;
    logic [15:0] data_in;
    logic        write_enable;
    logic        read_enable;
    logic [15:0] data_out;

    logic [15:0] ref_mem [256];
    logic [15:0] ref_out;
    int          n_compared   = 0;
    int          n_mismatched = 0;

    always #5 clk = ~clk;

    memory dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .data_in      (data_in),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_out     (data_out)
    );

    task automatic check_value(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive at negedge, update the model at the edge, compare,
    // then scribble on the inputs between edges to show they are ignored.
    task automatic step(input logic rst, input logic we, input logic re,
                        input logic [7:0] addr, input logic [15:0] din);
        @(negedge clk);
        rst_n        = rst;
        write_enable = we;
        read_enable  = re;
        address      = addr;
        data_in      = din;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
            ref_out = 16'h0000;
        end else begin
            if (re) ref_out = we ? din : ref_mem[addr];
            if (we) ref_mem[addr] = din;
        end
        #1;
        check_value("model", data_out, ref_out);
        rst_n        = 1'($urandom);
        write_enable = 1'($urandom);
        read_enable  = 1'($urandom);
        address      = 8'($urandom);
        data_in      = 16'($urandom);
    endtask

    initial begin
        logic [7:0] a;
        ref_out = 16'h0000;
        rst_n = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
        address = 8'h00; data_in = 16'h0000;

        step(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 8'h05, 16'hFFFF);
        check_value("reset_out", data_out, 16'h0000);

        step(1'b1, 1'b0, 1'b1, 8'h00, 16'h0000);
        check_value("read0_after_reset", data_out, 16'h0000);

        step(1'b1, 1'b1, 1'b0, 8'h00, 16'h1234);
        step(1'b1, 1'b0, 1'b1, 8'h00, 16'h0000);
        check_value("write_read_0", data_out, 16'h1234);

        step(1'b1, 1'b1, 1'b1, 8'h10, 16'hBEEF);
        check_value("write_first", data_out, 16'hBEEF);

        step(1'b1, 1'b1, 1'b0, 8'h00, 16'hAAAA);
        step(1'b1, 1'b1, 1'b0, 8'hFF, 16'h5555);
        step(1'b1, 1'b0, 1'b1, 8'h00, 16'h0000);
        check_value("bound_low", data_out, 16'hAAAA);
        step(1'b1, 1'b0, 1'b1, 8'hFF, 16'h0000);
        check_value("bound_high", data_out, 16'h5555);
        step(1'b1, 1'b0, 1'b1, 8'h01, 16'h0000);
        check_value("untouched_01", data_out, 16'h0000);

        step(1'b1, 1'b1, 1'b0, 8'h00, 16'h1234);
        step(1'b1, 1'b0, 1'b1, 8'h00, 16'h0000);
        check_value("hold_read", data_out, 16'h1234);
        step(1'b1, 1'b1, 1'b0, 8'h00, 16'h9999);
        check_value("hold_on_write", data_out, 16'h1234);
        step(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        check_value("hold_idle", data_out, 16'h1234);
        step(1'b1, 1'b0, 1'b1, 8'h00, 16'h0000);
        check_value("read_after_hold", data_out, 16'h9999);

        step(1'b1, 1'b1, 1'b0, 8'h00, 16'h1234);
        step(1'b0, 1'b1, 1'b0, 8'h00, 16'h7777);
        check_value("reset_discard_out", data_out, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 8'h00, 16'h0000);
        check_value("reset_discard_mem", data_out, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 8'hFF, 16'h0000);
        check_value("reset_clears_ff", data_out, 16'h0000);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 8'h00;
                1:       a = 8'hFF;
                default: a = 8'($urandom_range(0, 31));
            endcase
            step(($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom), a,
                 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
